// File: rtl/dspl_pkg.sv
// Shared definitions for the display scan controller.
//   state_t    : scan FSM state (BLANK dead-time, DRIVE digit slot)
//   SEG_TABLE  : hex nibble -> active-low segments, bit order {g,f,e,d,c,b,a}
//   SEG_OFF    : all segments dark
//   AN_OFF     : all anodes dark
package dspl_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } state_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [7:0] AN_OFF  = 8'hFF;

    // Active-low {g,f,e,d,c,b,a}; lower-case b and d keep them distinct from 8 and 0.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
        7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
        7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
        7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
    };

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex to 7-segment decoder.
//   nib : 4-bit hex value
//   seg : active-low segments {g,f,e,d,c,b,a}
module seg7_decode
    import dspl_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[nib];

endmodule

// File: rtl/dspl_scan_ctrl.sv
// Eight-digit multiplexed 7-segment scan controller.
// Each digit gets a slot of BLANK_CYCLES dead-time followed by HALF_MS_COUNT
// cycles of drive; digits are scanned 0..7. Digit data is captured at drive
// entry so mid-slot input changes only appear in the next slot.
//   clk_i, rst_i      : clock, synchronous active-high reset
//   digits_i          : eight hex nibbles, nibble k -> digit k
//   dp_i/en_i/blink_i : per-digit decimal point, enable, blink request
//   dspl_a..g, dspl_p : registered active-low segments / decimal point
//   dspl_an           : registered active-low anodes, bit k = digit k
//   frame_o           : one-cycle pulse when the digit 7 slot ends
module dspl_scan_ctrl
    import dspl_pkg::*;
#(
    parameter int HALF_MS_COUNT = 5,
    parameter int BLANK_CYCLES  = 2,
    parameter int BLINK_FRAMES  = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] digits_i,
    input  logic [7:0]  dp_i,
    input  logic [7:0]  en_i,
    input  logic [7:0]  blink_i,
    output logic        dspl_a,
    output logic        dspl_b,
    output logic        dspl_c,
    output logic        dspl_d,
    output logic        dspl_e,
    output logic        dspl_f,
    output logic        dspl_g,
    output logic        dspl_p,
    output logic [7:0]  dspl_an,
    output logic        frame_o
);

    localparam int CMAX = (HALF_MS_COUNT > BLANK_CYCLES) ? HALF_MS_COUNT : BLANK_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int BW   = $clog2(BLINK_FRAMES + 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [BW-1:0]   bcnt_q, bcnt_d;
    logic            phase_q, phase_d;
    logic [7:0]      an_q, an_d;
    logic [6:0]      seg_q, seg_d;
    logic            dp_q, dp_d;
    logic            frame_q, frame_d;

    logic [3:0]      cur_nib;
    logic [6:0]      cur_seg;
    logic            lit;

    assign cur_nib = digits_i[{idx_q, 2'b00} +: 4];

    seg7_decode u_dec (
        .nib (cur_nib),
        .seg (cur_seg)
    );

    // Output registers are loaded only on slot boundaries, which is what
    // latches the digit's data for the whole DRIVE slot.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        bcnt_d  = bcnt_q;
        phase_d = phase_q;
        an_d    = an_q;
        seg_d   = seg_q;
        dp_d    = dp_q;
        frame_d = 1'b0;
        lit     = en_i[idx_q] & ~(blink_i[idx_q] & phase_q);
        case (state_q)
            BLANK: begin
                if (cnt_q == CW'(BLANK_CYCLES - 1)) begin
                    state_d = DRIVE;
                    cnt_d   = '0;
                    if (lit) begin
                        an_d  = ~(8'b1 << idx_q);
                        seg_d = cur_seg;
                        dp_d  = ~dp_i[idx_q];
                    end else begin
                        an_d  = AN_OFF;
                        seg_d = SEG_OFF;
                        dp_d  = 1'b1;
                    end
                end
            end
            DRIVE: begin
                if (cnt_q == CW'(HALF_MS_COUNT - 1)) begin
                    state_d = BLANK;
                    cnt_d   = '0;
                    idx_d   = idx_q + 3'd1;
                    an_d    = AN_OFF;
                    seg_d   = SEG_OFF;
                    dp_d    = 1'b1;
                    if (idx_q == 3'd7) begin
                        frame_d = 1'b1;
                        if (bcnt_q == BW'(BLINK_FRAMES - 1)) begin
                            bcnt_d  = '0;
                            phase_d = ~phase_q;
                        end else begin
                            bcnt_d  = bcnt_q + 1'b1;
                        end
                    end
                end
            end
            default: state_d = BLANK;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= BLANK;
            cnt_q   <= '0;
            idx_q   <= '0;
            bcnt_q  <= '0;
            phase_q <= 1'b0;
            an_q    <= AN_OFF;
            seg_q   <= SEG_OFF;
            dp_q    <= 1'b1;
            frame_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            frame_q <= frame_d;
        end
    end

    assign {dspl_g, dspl_f, dspl_e, dspl_d, dspl_c, dspl_b, dspl_a} = seg_q;
    assign dspl_p  = dp_q;
    assign dspl_an = an_q;
    assign frame_o = frame_q;

endmodule

// File: tb/tb_dspl_scan_ctrl.sv
// Self-checking bench for dspl_scan_ctrl: per-cycle expectations derived from
// slot timing arithmetic, queued on drive and compared after each edge.
module tb_dspl_scan_ctrl;

    localparam int HM   = 5;
    localparam int BC   = 2;
    localparam int BF   = 2;
    localparam int SLOT = HM + BC;
    localparam logic [16:0] IDLE = {8'hFF, 7'h7F, 1'b1, 1'b0};

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] digits_i = '0;
    logic [7:0]  dp_i = '0, en_i = '0, blink_i = '0;
    logic        dspl_a, dspl_b, dspl_c, dspl_d, dspl_e, dspl_f, dspl_g, dspl_p;
    logic [7:0]  dspl_an;
    logic        frame_o;

    dspl_scan_ctrl #(
        .HALF_MS_COUNT (HM),
        .BLANK_CYCLES  (BC),
        .BLINK_FRAMES  (BF)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .digits_i (digits_i),
        .dp_i     (dp_i),
        .en_i     (en_i),
        .blink_i  (blink_i),
        .dspl_a   (dspl_a),
        .dspl_b   (dspl_b),
        .dspl_c   (dspl_c),
        .dspl_d   (dspl_d),
        .dspl_e   (dspl_e),
        .dspl_f   (dspl_f),
        .dspl_g   (dspl_g),
        .dspl_p   (dspl_p),
        .dspl_an  (dspl_an),
        .frame_o  (frame_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] dig;
        logic [7:0]  dp;
        logic [7:0]  en;
        logic [7:0]  blink;
        int          ncyc;
        logic [7:0]  exp_an2;
        logic [6:0]  exp_seg2;
        logic        exp_p2;
    } vec_t;

    vec_t        vecs [4];
    logic [6:0]  hexseg [16];   // active-high {g,f,e,d,c,b,a}
    logic [16:0] sbq [$];
    int          nvec = 0, nerr = 0, t = 0;
    logic [3:0]  l_nib;
    logic        l_dp, l_en, l_bl;

    function automatic logic [16:0] act();
        return {dspl_an, dspl_g, dspl_f, dspl_e, dspl_d, dspl_c, dspl_b, dspl_a, dspl_p, frame_o};
    endfunction

    task automatic check(input string nm, input logic [16:0] a, input logic [16:0] e);
        nvec++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s t=%0d got an=%h seg=%h p=%b fr=%b want an=%h seg=%h p=%b fr=%b",
                     nm, t, a[16:9], a[8:2], a[1], a[0], e[16:9], e[8:2], e[1], e[0]);
        end
    endtask

    // Cycle t after release: digit k drive begins at t = BC + k*SLOT.
    task automatic step(input string nm);
        int v, s, pos, d, f;
        logic [16:0] e;
        logic lit;
        t++;
        v = t - BC;
        e = IDLE;
        if (v >= 0) begin
            s = v / SLOT; pos = v % SLOT; d = s % 8; f = s / 8;
            if (pos == 0) begin
                l_nib = digits_i[d*4 +: 4];
                l_dp  = dp_i[d];
                l_en  = en_i[d];
                l_bl  = blink_i[d];
            end
            lit = l_en && !(l_bl && ((f / BF) % 2 == 1));
            if (pos < HM && lit)
                e = {~(8'd1 << d), ~hexseg[l_nib], ~l_dp, 1'b0};
            if (pos == HM && d == 7)
                e[0] = 1'b1;
        end
        sbq.push_back(e);
        @(posedge clk_i); #1;
        e = sbq.pop_front();
        check(nm, act(), e);
    endtask

    task automatic do_reset(input int n, input string nm);
        rst_i = 1'b1;
        repeat (n) begin
            @(posedge clk_i); #1;
            check(nm, act(), IDLE);
        end
        rst_i = 1'b0;
        t = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog t=%0d", t);
        $fatal(1, "timeout");
    end

    initial begin
        hexseg = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                   7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        vecs[0] = '{32'h76543210, 8'h00, 8'hFF, 8'h00, 60,  8'hFE, 7'h40, 1'b1};
        vecs[1] = '{32'h76543210, 8'h01, 8'h0F, 8'h00, 120, 8'hFE, 7'h40, 1'b0};
        vecs[2] = '{32'h76543210, 8'h00, 8'hFF, 8'h01, 340, 8'hFE, 7'h40, 1'b1};
        vecs[3] = '{32'hFEDCBA98, 8'hAA, 8'hFF, 8'h00, 60,  8'hFE, 7'h00, 1'b1};

        // Long reset: outputs idle throughout.
        digits_i = 32'h76543210; en_i = 8'hFF;
        do_reset(50, "reset_hold");

        foreach (vecs[i]) begin
            digits_i = vecs[i].dig; dp_i = vecs[i].dp;
            en_i = vecs[i].en; blink_i = vecs[i].blink;
            do_reset(2, "reset_vec");
            for (int c = 0; c < vecs[i].ncyc; c++) begin
                step("scan");
                if (t == 2)
                    check("vec_first", act(), {vecs[i].exp_an2, vecs[i].exp_seg2, vecs[i].exp_p2, 1'b0});
            end
        end

        // Nibble 0 changes mid digit-0 slot: old value held, new one next frame.
        digits_i = 32'h76543210; dp_i = '0; en_i = 8'hFF; blink_i = '0;
        do_reset(2, "reset_mid");
        repeat (3) step("midslot");
        digits_i = 32'h7654321A;
        while (t < 6) step("midslot");
        check("midslot_old", act(), {8'hFE, 7'h40, 1'b1, 1'b0});
        while (t < 58) step("midslot");
        check("midslot_new", act(), {8'hFE, 7'h08, 1'b1, 1'b0});
        while (t < 64) step("midslot");

        // One-cycle reset in the digit 5 slot, then clean restart.
        digits_i = 32'h76543210;
        do_reset(2, "reset_pre");
        while (t < 38) step("pre_rst");
        do_reset(1, "rst_mid_slot");
        repeat (12) step("post_rst");
        check("post_rst_d1", act(), {8'hFD, 7'h79, 1'b1, 1'b0});

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/dspl_scan_ctrl.md
DSPL_SCAN_CTRL -- requirements
Module: dspl_scan_ctrl

Interface
REQ-001 The block SHALL have parameter HALF_MS_COUNT, default 5, giving the DRIVE slot length in clk_i cycles (legal values >= 1).
REQ-002 The block SHALL have parameter BLANK_CYCLES, default 2, giving the dead-time between slots in cycles (legal values >= 1).
REQ-003 The block SHALL have parameter BLINK_FRAMES, default 2, giving the number of full frames per blink phase (legal values >= 1).
REQ-004 The block SHALL have port clk_i, input, 1 bit: the single clock.
REQ-005 The block SHALL have port rst_i, input, 1 bit: reset, synchronous, active-high.
REQ-006 The block SHALL have port digits_i, input, 32 bits: eight hex nibbles; nibble k (bits 4k+3:4k) drives digit k.
REQ-007 The block SHALL have port dp_i, input, 8 bits: decimal point request per digit, active-high.
REQ-008 The block SHALL have port en_i, input, 8 bits: digit enable per digit, active-high.
REQ-009 The block SHALL have port blink_i, input, 8 bits: blink request per digit, active-high.
REQ-010 The block SHALL have ports dspl_a..dspl_g and dspl_p, output, 1 bit each: segments and decimal point, active-low.
REQ-011 The block SHALL have port dspl_an, output, 8 bits: digit anodes, active-low, bit k = digit k.
REQ-012 The block SHALL have port frame_o, output, 1 bit: one-cycle pulse at frame end.

Function
REQ-013 The block SHALL time-multiplex digits 0..7 in ascending order onto the shared segment bus using an FSM with two states, BLANK and DRIVE.
REQ-014 In BLANK, for exactly BLANK_CYCLES cycles, dspl_an SHALL be 8'hFF and all segment outputs and dspl_p SHALL be 1.
REQ-015 In DRIVE, for exactly HALF_MS_COUNT cycles, the outputs SHALL present the current digit idx.
REQ-016 The DRIVE to BLANK transition SHALL advance idx modulo 8, with 7 wrapping to 0.
REQ-017 The digit period SHALL be HALF_MS_COUNT+BLANK_CYCLES cycles, and the frame period SHALL be 8 times that.
REQ-018 Nibble idx, dp_i[idx], en_i[idx] and blink_i[idx] SHALL be latched on the cycle of BLANK to DRIVE entry and held for the whole slot; input changes mid-slot SHALL have no visible effect until the next slot.
REQ-019 The segment encoding SHALL be full hex 0-F in standard 7-segment form; "0" SHALL be a-f low, g high; "A" SHALL be a,b,c,e,f,g low, d high.
REQ-020 A digit SHALL be dark (anode high, segments and dp high) when its latched enable is 0, or when its latched blink is 1 and blink_phase is 1; its slot timing SHALL be unchanged.
REQ-021 dspl_p SHALL be low only when the digit is lit and its latched dp is 1.
REQ-022 blink_phase SHALL toggle after every BLINK_FRAMES completed frames; the blink frame counter SHALL wrap silently.
REQ-023 frame_o SHALL be 1 for exactly the one cycle of the DRIVE to BLANK transition out of digit 7.
REQ-024 At most one dspl_an bit SHALL be low at any cycle.
REQ-025 All outputs SHALL be registered with no combinational input-to-output path.

Reset
REQ-026 While rst_i is high on a clock edge, the next state SHALL be: BLANK, idx=0, slot counter=0, blink counter=0, blink_phase=0, dspl_an=8'hFF, segments and dspl_p=1, frame_o=0.
REQ-027 After the first cycle with rst_i low, the block SHALL hold BLANK for BLANK_CYCLES cycles, then DRIVE digit 0.
REQ-028 Reset asserted mid-DRIVE or mid-BLANK SHALL blank all outputs on the next edge, and the sequence SHALL restart per REQ-027 with no frame_o.

Structure
REQ-029 The shared package dspl_pkg SHALL hold the FSM state typedef (BLANK, DRIVE), the 16-entry hex-to-segment constant table, and the SEG_OFF/AN_OFF constants.
REQ-030 Hex decode SHALL be implemented in the one combinational sub-module seg7_decode (4-bit in, 7-bit active-low out); all sequencing SHALL reside in dspl_scan_ctrl.

Verification
REQ-031 The bench SHALL cover reset: rst_i high 50 cycles -> dspl_an=8'hFF, segments=1, frame_o=0 throughout.
REQ-032 The bench SHALL cover scan order and timing: digits_i=32'h76543210, en_i=8'hFF, blink_i=0 -> dspl_an=8'hFE from cycle 2 to 6 after release with "0" pattern, then 8'hFD from cycle 9 with "1", and so on; frame_o at cycle 56.
REQ-033 The bench SHALL cover enable mask: en_i=8'h0F -> slots 4-7 keep dspl_an=8'hFF with the 7-cycle slot timing unchanged; dp_i=8'h01 -> dspl_p low only during the digit 0 slot.
REQ-034 The bench SHALL cover blink: blink_i=8'h01, BLINK_FRAMES=2 -> digit 0 lit in frames 0-1, dark in frames 2-3, lit in frames 4-5.
REQ-035 The bench SHALL cover a mid-slot change: digits_i nibble 0 changed from 0 to A at cycle 3 of the digit 0 slot -> "0" held to slot end; the next frame shows "A".
REQ-036 The bench SHALL cover reset mid-operation: rst_i pulsed one cycle during the digit 5 slot -> dspl_an=8'hFF next cycle; digit 0 DRIVE begins BLANK_CYCLES cycles after release.
